// File: rtl/div_issue_ctrl.sv
// Execute-stage issue control for the iterative divider. It issues DIV/DIVU, holds operands and sign mode
// while the divider runs, stalls the pipe and forwards the {rem, quot} result as a HI/LO write.
module div_issue_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        op_div_i,
  input  logic        op_divu_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_signed_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   op1_q, op1_d, op2_q, op2_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          sgn_q, sgn_d;

  logic          op_any, req;
  logic          start_c, annul_c, stall_c, we_c, sgn_c;
  logic [31:0]   opd1_c, opd2_c, hi_c, lo_c;

  assign op_any = op_div_i | op_divu_i;
  assign req    = op_any & ~flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start_c = 1'b0;
    annul_c = 1'b0;
    stall_c = 1'b0;
    we_c    = 1'b0;
    hi_c    = '0;
    lo_c    = '0;
    opd1_c  = op1_q;
    opd2_c  = op2_q;
    sgn_c   = sgn_q;

    unique case (state_q)
      S_IDLE: begin
        annul_c = flush_i & op_any;
        if (req) begin
          // Issue cycle: the divider sees the live operands before the latches fill.
          op1_d   = reg1_i;
          op2_d   = reg2_i;
          sgn_d   = op_div_i;
          opd1_c  = reg1_i;
          opd2_c  = reg2_i;
          sgn_c   = op_div_i;
          start_c = 1'b1;
          stall_c = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        annul_c = flush_i;
        if (flush_i) begin
          cnt_d   = CW'(DRAIN_CYCLES);
          state_d = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          we_c    = 1'b1;
          hi_c    = div_result_i[63:32];
          lo_c    = div_result_i[31:0];
          state_d = S_DONE;
        end else begin
          start_c = 1'b1;
          stall_c = 1'b1;
        end
      end
      S_DONE: begin
        we_c = ~flush_i;
        hi_c = flush_i ? '0 : hi_q;
        lo_c = flush_i ? '0 : lo_q;
        if (flush_i || !stall_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // A new op waits here; the divider is still settling from the abort.
        stall_c = req;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign div_opdata1_o = rst ? '0 : opd1_c;
  assign div_opdata2_o = rst ? '0 : opd2_c;
  assign div_signed_o  = sgn_c & ~rst;
  assign div_start_o   = start_c & ~rst;
  assign div_annul_o   = annul_c & ~rst;
  assign stallreq_o    = stall_c & ~rst;
  assign hilo_we_o     = we_c & ~rst;
  assign hi_o          = rst ? '0 : hi_c;
  assign lo_o          = rst ? '0 : lo_c;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Transaction-scripted bench for div_issue_ctrl: each divide is played out cycle by cycle from its
// timeline (issue, busy, ready, done/stall, flush, drain) and every output is compared on the falling edge.
module tb_div_issue_ctrl;
  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, op_div_i, op_divu_i, div_ready_i;
  logic [31:0] reg1_i, reg2_i;
  logic [63:0] div_result_i;
  logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
  logic        div_signed_o, div_start_o, div_annul_o, stallreq_o, hilo_we_o;

  div_issue_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .op_div_i(op_div_i), .op_divu_i(op_divu_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o), .div_signed_o(div_signed_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .stallreq_o(stallreq_o),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  logic        e_start, e_annul, e_stall, e_we, e_sgn, e_opchk;
  logic [31:0] e_hi, e_lo, e_op1, e_op2;
  int          checks = 0, errors = 0, rises = 0, issued = 0;
  logic        prev_start = 1'b0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("start",    32'(div_start_o), 32'(e_start));
      chk("annul",    32'(div_annul_o), 32'(e_annul));
      chk("stallreq", 32'(stallreq_o),  32'(e_stall));
      chk("hilo_we",  32'(hilo_we_o),   32'(e_we));
      chk("hi",       hi_o, e_hi);
      chk("lo",       lo_o, e_lo);
      if (e_opchk) begin
        chk("opdata1", div_opdata1_o, e_op1);
        chk("opdata2", div_opdata2_o, e_op2);
        chk("signed",  32'(div_signed_o), 32'(e_sgn));
      end
      if (div_start_o && !prev_start) rises++;
      prev_start = div_start_o;
    end
  end

  // Reference divider: truncating division, remainder takes the dividend's sign, x/0 gives 0/0.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
    sa = a; sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    e_start = 0; e_annul = 0; e_stall = 0; e_we = 0; e_sgn = 0; e_opchk = 0;
    e_hi = '0; e_lo = '0; e_op1 = '0; e_op2 = '0;
  endtask

  task automatic busy_exp(input logic [31:0] a, input logic [31:0] b, input logic s);
    e_start = 1; e_stall = 1; e_opchk = 1; e_op1 = a; e_op2 = b; e_sgn = s;
  endtask

  task automatic do_op(input logic dv, input logic both, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int flush_at, input int stall_n, input logic flush_done,
                       input logic use_lit, input logic [31:0] lh, input logic [31:0] ll,
                       output logic flushed);
    logic [63:0] res, er;
    res = div_model(a, b, dv);
    er  = use_lit ? {lh, ll} : res;
    flushed = 1'b0;
    op_div_i = dv; op_divu_i = ~dv | both; reg1_i = a; reg2_i = b;
    flush_i = 0; stall_i = 1'($urandom); div_ready_i = 1'($urandom); div_result_i = rnd64();
    clr_exp(); busy_exp(a, b, dv); issued++;
    step();
    for (int c = 1; c <= lat; c++) begin
      stall_i = 1'($urandom);
      if (c == flush_at) begin
        flush_i = 1; div_ready_i = 1'($urandom); div_result_i = (c == lat) ? res : rnd64();
        clr_exp(); e_annul = 1;
        step();
        flush_i = 0; flushed = 1'b1;
        return;
      end else if (c == lat) begin
        div_ready_i = 1; div_result_i = res;
        clr_exp(); e_we = 1; e_hi = er[63:32]; e_lo = er[31:0];
      end else begin
        div_ready_i = 0; div_result_i = rnd64();
        clr_exp(); busy_exp(a, b, dv);
      end
      step();
    end
    for (int s = 0; s < stall_n; s++) begin
      stall_i = 1; div_ready_i = 1'($urandom); div_result_i = rnd64();
      clr_exp(); e_we = 1; e_hi = er[63:32]; e_lo = er[31:0];
      step();
    end
    stall_i = flush_done ? 1'($urandom) : 1'b0;
    flush_i = flush_done;
    op_div_i = 1'($urandom); op_divu_i = 1'($urandom); reg1_i = $urandom; reg2_i = $urandom;
    div_ready_i = 1'($urandom); div_result_i = rnd64();
    clr_exp();
    if (!flush_done) begin e_we = 1; e_hi = er[63:32]; e_lo = er[31:0]; end
    step();
    flush_i = 0;
  endtask

  task automatic drain(input logic present, input logic dv, input logic [31:0] a, input logic [31:0] b,
                       input logic rnd_flush);
    for (int k = 0; k < DRAIN; k++) begin
      op_div_i = present & dv; op_divu_i = present & ~dv; reg1_i = a; reg2_i = b;
      flush_i = rnd_flush ? ($urandom_range(0, 3) == 0) : 1'b0;
      stall_i = 1'($urandom); div_ready_i = 1'($urandom); div_result_i = rnd64();
      clr_exp(); e_stall = present & ~flush_i;
      step();
    end
    flush_i = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 1) begin
        op_div_i = 1'($urandom); op_divu_i = ~op_div_i; flush_i = 1;
      end else begin
        op_div_i = 0; op_divu_i = 0; flush_i = 1'($urandom);
      end
      reg1_i = $urandom; reg2_i = $urandom;
      stall_i = 1'($urandom); div_ready_i = 1'($urandom); div_result_i = rnd64();
      clr_exp(); e_annul = (op_div_i | op_divu_i) & flush_i;
      step();
    end
    flush_i = 0;
  endtask

  task automatic mid_reset();
    op_div_i = 1; op_divu_i = 0; reg1_i = 32'd77; reg2_i = 32'd5;
    flush_i = 0; stall_i = 0; div_ready_i = 0; div_result_i = rnd64();
    clr_exp(); busy_exp(32'd77, 32'd5, 1'b1); issued++;
    step();
    for (int k = 0; k < 3; k++) step();
    rst = 1; div_ready_i = 1;
    clr_exp(); e_opchk = 1;
    step(); step();
    rst = 0; op_div_i = 0; div_ready_i = 1;
    clr_exp();
    step();
  endtask

  initial begin
    logic fl;
    logic dv, both, fd;
    logic [31:0] a, b;
    int lat, fa, sn;
    rst = 1; stall_i = 1; flush_i = 0; op_div_i = 1; op_divu_i = 1;
    reg1_i = 32'hDEAD_BEEF; reg2_i = 32'h1234_5678; div_ready_i = 1; div_result_i = rnd64();
    clr_exp(); e_opchk = 1;
    step();
    chk_en = 1;
    step(); step();
    rst = 0; op_div_i = 0; op_divu_i = 0; stall_i = 0; div_ready_i = 0;
    clr_exp();
    step();

    do_op(1, 0, 32'hFFFF_FFF9, 32'd2, 34, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, fl);
    idle(1);
    do_op(0, 0, 32'd100, 32'd7, 34, 0, 0, 0, 1, 32'd2, 32'd14, fl);
    do_op(1, 0, 32'd5, 32'd0, 34, 0, 0, 0, 1, 32'd0, 32'd0, fl);
    do_op(1, 0, 32'd37, 32'd5, 20, 0, 0, 0, 1, 32'd2, 32'd7, fl);
    do_op(1, 0, 32'd1000, 32'd3, 34, 10, 0, 0, 0, 32'd0, 32'd0, fl);
    drain(1, 0, 32'd9, 32'd4, 0);
    do_op(0, 0, 32'd9, 32'd4, 34, 0, 0, 0, 1, 32'd1, 32'd2, fl);
    do_op(0, 0, 32'd50, 32'd8, 30, 0, 5, 0, 1, 32'd2, 32'd6, fl);
    do_op(0, 0, 32'd10, 32'd3, 33, 0, 0, 0, 1, 32'd1, 32'd3, fl);
    do_op(0, 0, 32'd20, 32'd6, 33, 0, 0, 0, 1, 32'd2, 32'd3, fl);
    do_op(1, 1, 32'hFFFF_FFF0, 32'd3, 12, 0, 2, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, fl);
    do_op(1, 0, 32'd8, 32'd2, 5, 5, 0, 0, 0, 32'd0, 32'd0, fl);
    drain(0, 0, 32'd0, 32'd0, 1);
    mid_reset();

    for (int t = 0; t < 40; t++) begin
      dv   = 1'($urandom);
      both = dv & ($urandom_range(0, 3) == 0);
      a    = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 500);
      b    = ($urandom_range(0, 7) == 0) ? 32'd0 :
             (($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 50));
      lat  = $urandom_range(1, 40);
      fa   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      sn   = $urandom_range(0, 4);
      fd   = ($urandom_range(0, 5) == 0);
      do_op(dv, both, a, b, lat, fa, sn, fd, 0, 32'd0, 32'd0, fl);
      if (fl) drain(1'($urandom), 1'($urandom), $urandom, $urandom, 1);
      idle($urandom_range(0, 2));
    end

    chk("start_rises", rises, issued);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
